parity_frame_tx: RTL and testbench
==================================

Name: parity_frame_tx

Overview:
Serialising transmitter for the error-detect path. It accepts a parallel data word over a valid/ready handshake and computes its parity bit at acceptance. It then drives the word LSB-first onto a 1-bit serial line, followed by the parity bit. The downstream receiver/checker recomputes parity and flags a mismatch (equality check of computed vs received parity).

Parameters:
DATA_W, 8, payload width in bits (>=2)
ODD_PARITY, 0, 0 = even parity (parity bit = XOR of data); 1 = odd parity (parity bit = XNOR of data)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-high
data_in  in  DATA_W  parallel word to send
in_valid  in  1  data_in is valid
in_ready  out  1  block can accept a word this cycle
ser_out  out  1  serial bit (data LSB-first, then parity)
ser_valid  out  1  ser_out carries a frame bit this cycle
frame_start  out  1  high on the cycle carrying data bit 0
parity_slot  out  1  high on the cycle carrying the parity bit
busy  out  1  a frame is in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset, applied asynchronously:
  - state = IDLE; shift register = 0; bit counter = 0; stored parity = 0.
  - ser_out = 0, ser_valid = 0, frame_start = 0, parity_slot = 0, busy = 0, in_ready = 1.
- Output timing: all serial outputs are registered. in_ready and busy are decoded from state only, with no combinational path from in_valid.
- FSM states: IDLE, DATA, PARITY.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch data_in into the shift register, latch the parity bit (^data_in, or ~^data_in if ODD_PARITY), clear the counter, go to DATA.
- DATA:
  - Each cycle: ser_out = shreg[0], ser_valid = 1, then shift right and increment the counter.
  - frame_start = 1 only when counter = 0.
  - After DATA_W bits (counter = DATA_W-1), go to PARITY.
- PARITY (one cycle):
  - ser_out = stored parity, ser_valid = 1, parity_slot = 1.
  - in_ready = 1 here, for back-to-back frames.
  - If a handshake occurs, latch the new word and go straight to DATA; otherwise go to IDLE.
- Latency: bit 0 of an accepted word appears on ser_out in the cycle after the accepting edge.
- Frame length: DATA_W+1 cycles. Sustained throughput is one word per DATA_W+1 cycles, with no gap cycles between back-to-back frames.
- In DATA, in_ready = 0. in_valid is ignored and data_in changes have no effect on the frame in flight.
- Idle line: ser_valid = 0 and ser_out = 0 whenever no frame bit is being driven.
- Reset mid-frame: the frame is abandoned. Outputs go to reset values immediately (asynchronously), and no partial parity bit is emitted. After reset deasserts, the next accepted word starts a fresh frame.
- Counter width: $clog2(DATA_W). The counter never wraps inside a frame.

Decomposition:
- Shared package parity_pkg:
  - state enum (IDLE/DATA/PARITY)
  - EVEN/ODD parity constants
  - function calc_parity(data, odd), reused by the checker side
- One natural sub-module: parity_gen, a combinational reduce-XOR with odd/even select. The transmitter instantiates it at the acceptance point, and the receiver/checker reuses it.

Test Plan:
1. Reset, then DATA_W=8, even, send 8'hA5 -> in_ready high after reset; ser_out bits over 9 cycles = 1,0,1,0,0,1,0,1, parity 0; frame_start on cycle 1 only; parity_slot on cycle 9 only.
2. Even parity, send 8'h07 -> data bits 1,1,1,0,0,0,0,0, parity 1. With ODD_PARITY=1, send 8'h00 -> 8 zeros, parity 1.
3. Back-to-back: in_valid held high with 8'hFF then 8'h01 -> second frame_start on the cycle immediately after the first parity_slot; parities 0 then 1; ser_valid never drops between frames.
4. Busy-ignore: during DATA, toggle in_valid and data_in -> in_ready = 0; the frame in flight is unchanged; no extra frame is emitted.
5. Reset mid-frame: assert rst after 3 data bits -> ser_valid/busy fall immediately (not waiting for clk); no parity bit is emitted; after release, in_ready = 1 and 8'h3C is sent cleanly.
6. Loopback: feed ser_out into the matching parity checker for all 256 words with even parity -> zero mismatches. Flip one bit in flight -> the checker reports a mismatch.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity frame path.
// Used by the transmitter and by the receive-side checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam int MAX_W = 64;

  // Zero padding leaves the XOR unchanged, so one width serves all.
  function automatic logic calc_parity(
    input logic [MAX_W-1:0] data,
    input logic             odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_tx_gen.sv
// Combinational parity generator, even or odd.
// Shared between transmitter and receive checker.
module parity_gen
  import parity_pkg::*;
#(
  parameter int   W       = 8,
  parameter logic ODD_SEL = EVEN
) (
  input  logic [W-1:0] data_i,
  output logic         parity_o
);

  always_comb begin
    parity_o = calc_parity(MAX_W'(data_i), ODD_SEL);
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Serialising transmitter: word LSB-first, then parity bit.
// Serial outputs are flops; in_ready/busy decode state only.
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              parity_slot,
  output logic              busy
);

  localparam int CW =
    (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DATA_W - 1);
  localparam logic ODD_SEL =
    (ODD_PARITY != 0) ? ODD : EVEN;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              ser_q, ser_d;
  logic              sv_q, sv_d;
  logic              fs_q, fs_d;
  logic              ps_q, ps_d;
  logic              par_new;
  logic              accept;

  parity_gen #(
    .W       (DATA_W),
    .ODD_SEL (ODD_SEL)
  ) u_pgen (
    .data_i   (data_in),
    .parity_o (par_new)
  );

  assign in_ready = (state_q != DATA);
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid & in_ready;

  assign ser_out     = ser_q;
  assign ser_valid   = sv_q;
  assign frame_start = fs_q;
  assign parity_slot = ps_q;

  // shreg_q holds the bits not yet driven;
  // cnt_q is the index of the bit now on the line.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    ser_d   = 1'b0;
    sv_d    = 1'b0;
    fs_d    = 1'b0;
    ps_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      DATA: begin
        if (cnt_q == LAST) begin
          state_d = PARITY;
          ser_d   = par_q;
          sv_d    = 1'b1;
          ps_d    = 1'b1;
        end else begin
          ser_d   = shreg_q[0];
          sv_d    = 1'b1;
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Acceptance is only possible in IDLE or PARITY.
    if (accept) begin
      state_d = DATA;
      shreg_d = data_in >> 1;
      cnt_d   = '0;
      par_d   = par_new;
      ser_d   = data_in[0];
      sv_d    = 1'b1;
      fs_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      ser_q   <= 1'b0;
      sv_q    <= 1'b0;
      fs_q    <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      ser_q   <= ser_d;
      sv_q    <= sv_d;
      fs_q    <= fs_d;
      ps_q    <= ps_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed + randomized bench for parity_frame_tx.
// Even and odd instances checked against a bit-count model.
module tb_parity_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in, o_data_in;
  logic       in_valid, o_in_valid;
  logic       in_ready, o_in_ready;
  logic       ser_out, o_ser_out;
  logic       ser_valid, o_ser_valid;
  logic       frame_start, o_frame_start;
  logic       parity_slot, o_parity_slot;
  logic       busy, o_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.DATA_W(8), .ODD_PARITY(0)) u_even (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .parity_slot (parity_slot),
    .busy        (busy)
  );

  parity_frame_tx #(.DATA_W(8), .ODD_PARITY(1)) u_odd (
    .clk         (clk),
    .rst         (rst),
    .data_in     (o_data_in),
    .in_valid    (o_in_valid),
    .in_ready    (o_in_ready),
    .ser_out     (o_ser_out),
    .ser_valid   (o_ser_valid),
    .frame_start (o_frame_start),
    .parity_slot (o_parity_slot),
    .busy        (o_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Parity from a plain count of ones.
  function automatic logic exp_par(input logic [7:0] d,
                                   input bit odd);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return ((n % 2) != 0) ^ odd;
  endfunction

  task automatic send(input bit sel, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin
      chk("rdy_odd", 32'(o_in_ready), 1);
      o_in_valid = 1'b1;
      o_data_in  = d;
    end else begin
      chk("rdy", 32'(in_ready), 1);
      in_valid = 1'b1;
      data_in  = d;
    end
    @(posedge clk);
    #1;
    o_in_valid = 1'b0;
    in_valid   = 1'b0;
    data_in    = 8'($urandom);
    o_data_in  = 8'($urandom);
  endtask

  task automatic grab(input bit sel,
                      output logic [8:0] b,
                      output logic [8:0] fs,
                      output logic [8:0] ps,
                      output logic [8:0] sv);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      b[k]  = sel ? o_ser_out     : ser_out;
      fs[k] = sel ? o_frame_start : frame_start;
      ps[k] = sel ? o_parity_slot : parity_slot;
      sv[k] = sel ? o_ser_valid   : ser_valid;
    end
  endtask

  task automatic frame_chk(input string tag,
                           input logic [7:0] d,
                           input bit odd,
                           input logic [8:0] b,
                           input logic [8:0] fs,
                           input logic [8:0] ps,
                           input logic [8:0] sv);
    chk({tag, "_bits"}, 32'(b), 32'({exp_par(d, odd), d}));
    chk({tag, "_fs"}, 32'(fs), 32'h001);
    chk({tag, "_ps"}, 32'(ps), 32'h100);
    chk({tag, "_sv"}, 32'(sv), 32'h1FF);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_idle_sv"}, 32'(ser_valid), 0);
    chk({tag, "_idle_so"}, 32'(ser_out), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    logic [8:0]  b, fs, ps, sv;
    logic [17:0] b2, fs2, ps2, sv2;
    logic [7:0]  d;
    logic        any;
    int          mm, derr, idx;

    rst        = 1'b1;
    in_valid   = 1'b0;
    data_in    = '0;
    o_in_valid = 1'b0;
    o_data_in  = '0;

    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sv", 32'(ser_valid), 0);
    chk("rst_so", 32'(ser_out), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_ps", 32'(parity_slot), 0);
    rst = 1'b0;

    // Basic even frames
    send(0, 8'hA5);
    grab(0, b, fs, ps, sv);
    frame_chk("a5", 8'hA5, 0, b, fs, ps, sv);
    chk("a5_literal", 32'(b), 32'h0A5);
    idle_chk("a5");

    send(0, 8'h07);
    grab(0, b, fs, ps, sv);
    frame_chk("07", 8'h07, 0, b, fs, ps, sv);
    chk("07_literal", 32'(b), 32'h107);

    // Odd instance
    send(1, 8'h00);
    grab(1, b, fs, ps, sv);
    frame_chk("odd00", 8'h00, 1, b, fs, ps, sv);
    chk("odd00_literal", 32'(b), 32'h100);

    for (int r = 0; r < 6; r++) begin
      d = 8'($urandom);
      send(0, d);
      grab(0, b, fs, ps, sv);
      frame_chk("rnd_even", d, 0, b, fs, ps, sv);
      d = 8'($urandom);
      send(1, d);
      grab(1, b, fs, ps, sv);
      frame_chk("rnd_odd", d, 1, b, fs, ps, sv);
    end

    // Back-to-back with in_valid held high
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = 8'hFF;
    @(posedge clk);
    #1;
    data_in = 8'h01;
    any = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      b2[k]  = ser_out;
      fs2[k] = frame_start;
      ps2[k] = parity_slot;
      sv2[k] = ser_valid;
      if (!busy) any = 1'b1;
      if (k == 9) in_valid = 1'b0;
    end
    chk("b2b_bits", 32'(b2),
        32'({exp_par(8'h01, 0), 8'h01,
             exp_par(8'hFF, 0), 8'hFF}));
    chk("b2b_fs", 32'(fs2), 32'h00201);
    chk("b2b_ps", 32'(ps2), 32'h20100);
    chk("b2b_sv", 32'(sv2), 32'h3FFFF);
    chk("b2b_busy_drop", 32'(any), 0);
    idle_chk("b2b");

    // Busy-ignore: wiggle inputs during DATA
    d = 8'($urandom);
    send(0, d);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      b[k]  = ser_out;
      fs[k] = frame_start;
      ps[k] = parity_slot;
      sv[k] = ser_valid;
      if (k < 8) chk("ign_ready", 32'(in_ready), 0);
      if (k < 7) begin
        in_valid = 1'($urandom);
        data_in  = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
    frame_chk("ign", d, 0, b, fs, ps, sv);
    any = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ser_valid) any = 1'b1;
    end
    chk("ign_extra", 32'(any), 0);

    // Reset mid-frame
    d = 8'($urandom);
    send(0, d);
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("mid_sv_before", 32'(ser_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_sv", 32'(ser_valid), 0);
    chk("mid_async_busy", 32'(busy), 0);
    chk("mid_async_rdy", 32'(in_ready), 1);
    chk("mid_async_so", 32'(ser_out), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    any = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ser_valid || parity_slot) any = 1'b1;
    end
    chk("mid_no_parity", 32'(any), 0);
    send(0, 8'h3C);
    grab(0, b, fs, ps, sv);
    frame_chk("3c", 8'h3C, 0, b, fs, ps, sv);

    // Loopback into a receive-side checker model
    mm   = 0;
    derr = 0;
    for (int w = 0; w < 256; w++) begin
      send(0, 8'(w));
      grab(0, b, fs, ps, sv);
      if (exp_par(b[7:0], 0) != b[8]) mm++;
      if (b[7:0] != 8'(w) || sv != 9'h1FF) derr++;
    end
    chk("loop_mismatch", 32'(mm), 0);
    chk("loop_data", 32'(derr), 0);
    idx = int'($urandom_range(8, 0));
    b[idx] = ~b[idx];
    chk("flip_detect",
        32'(exp_par(b[7:0], 0) != b[8]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
